// File: rtl/dma_writer_if.sv
// Memory write port of the FC write-side DMA: address, data and write enable.
// DMA_WRITER_STALL_EN adds the mem_ready back-pressure signal after mem_we.
interface dma_writer_if #(
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10
) ();
    logic [MEM_ADDRESS_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]         mem_data;
    logic                         mem_we;
`ifdef DMA_WRITER_STALL_EN
    logic                         mem_ready;
`endif

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we
`ifdef DMA_WRITER_STALL_EN
        , input mem_ready
`endif
    );

    modport slave (
        input mem_addr,
        input mem_data,
        input mem_we
`ifdef DMA_WRITER_STALL_EN
        , output mem_ready
`endif
    );
endinterface

// File: rtl/dma_writer.sv
// Snapshots a parallel word buffer on i_write and streams it to word-addressed memory.
// Optional DMA_WRITER_STALL_EN: writes advance only when the memory asserts mem_ready.
module dma_writer #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10
) (
    input  logic                                   clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_write,
    input  logic [MEM_ADDRESS_WIDTH-1:0]           i_address,
    input  logic [MEM_ADDRESS_WIDTH-1:0]           i_count,
    input  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0]  i_buffer,
    dma_writer_if.master                           mem,
    output logic                                   o_busy,
    output logic                                   o_done
);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [MEM_ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]         data_q, data_d;
    logic                         we_q, we_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [WORD_SIZE-1:0]         snap_q [BUFFER_SIZE];

    logic [CNT_W-1:0] count_clamped;
    logic [CNT_W-1:0] idx_inc;
    logic             accept;
    logic             snap_load;

`ifdef DMA_WRITER_STALL_EN
    assign accept = mem.mem_ready;
`else
    assign accept = 1'b1;
`endif

    assign idx_inc   = idx_q + 1'b1;
    assign snap_load = (state_q == IDLE) && i_write;

    always_comb begin
        if (int'(i_count) > BUFFER_SIZE) begin
            count_clamped = CNT_W'(BUFFER_SIZE);
        end else begin
            count_clamped = CNT_W'(i_count);
        end
    end

    // Word 0 is taken straight from i_buffer so it appears the cycle after acceptance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_write) begin
                    base_d  = i_address;
                    count_d = count_clamped;
                    idx_d   = '0;
                    if (count_clamped == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = i_address;
                        data_d  = i_buffer[0];
                    end
                end
            end
            WRITE: begin
                we_d   = 1'b1;
                busy_d = 1'b1;
                if (accept) begin
                    if (idx_q == count_q - 1'b1) begin
                        state_d = DONE;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        addr_d = base_q + MEM_ADDRESS_WIDTH'(idx_inc);
                        data_d = snap_q[idx_inc];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                snap_q[i] <= i_buffer[i];
            end
        end
    end

    assign mem.mem_addr = addr_q;
    assign mem.mem_data = data_q;
    assign mem.mem_we   = we_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_dma_writer.sv
// Randomized self-checking bench for dma_writer; cycle-by-cycle comparison against a
// queue-free reference that walks the clamped word list (honours DMA_WRITER_STALL_EN).
module tb_dma_writer;
    localparam int BS  = 120;
    localparam int WS  = 16;
    localparam int MAW = 10;

    logic                        clk;
    logic                        i_rst_n;
    logic                        i_write;
    logic [MAW-1:0]              i_address;
    logic [MAW-1:0]              i_count;
    logic [0:BS-1][WS-1:0]       i_buffer;
    logic                        o_busy;
    logic                        o_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [MAW-1:0] last_addr;
    logic [WS-1:0]  last_data;

    dma_writer_if #(.WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(MAW)) mem_if ();

    dma_writer #(
        .BUFFER_SIZE(BS),
        .WORD_SIZE(WS),
        .MEM_ADDRESS_WIDTH(MAW)
    ) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_write   (i_write),
        .i_address (i_address),
        .i_count   (i_count),
        .i_buffer  (i_buffer),
        .mem       (mem_if.master),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {we, busy, done, addr, data}
    function automatic logic [63:0] obs_bus();
        return 64'({mem_if.mem_we, o_busy, o_done, mem_if.mem_addr, mem_if.mem_data});
    endfunction

    function automatic logic [63:0] exp_bus(input bit we, input bit busy, input bit done,
                                            input logic [MAW-1:0] a, input logic [WS-1:0] d);
        return 64'({we, busy, done, a, d});
    endfunction

    task automatic rand_buffer();
        for (int i = 0; i < BS; i++) begin
            i_buffer[i] = WS'($urandom);
        end
    endtask

    // Caller is at a negedge with i_buffer already loaded. stall_mode: 0 none,
    // 1 random ready, 2 ready low for two cycles while word 1 is presented.
    task automatic run_xfer(input string name, input logic [MAW-1:0] addr,
                            input logic [MAW-1:0] cnt, input bit disturb, input int stall_mode);
        int n;
        int k;
        int low_left;
        int writes;
        bit rdy;
        bit seen_done;
        logic [WS-1:0] ebuf [BS];
        n = (int'(cnt) > BS) ? BS : int'(cnt);
        for (int i = 0; i < BS; i++) ebuf[i] = i_buffer[i];
        i_address = addr;
        i_count   = cnt;
        i_write   = 1'b1;
        @(posedge clk);
        k = 0;
        low_left = 2;
        writes = 0;
        seen_done = 1'b0;
        for (int cyc = 1; cyc <= n + 400 && !seen_done; cyc++) begin
            @(negedge clk);
            i_write = 1'b0;
            if (k < n) begin
                check("write", obs_bus(), exp_bus(1'b1, 1'b1, 1'b0, addr + MAW'(k), ebuf[k]));
                last_addr = addr + MAW'(k);
                last_data = ebuf[k];
                writes++;
                rdy = 1'b1;
                if (stall_mode == 1) rdy = ($urandom_range(0, 3) != 0);
                if (stall_mode == 2 && k == 1 && low_left > 0) begin
                    rdy = 1'b0;
                    low_left--;
                end
`ifdef DMA_WRITER_STALL_EN
                mem_if.mem_ready = rdy;
`else
                rdy = 1'b1;
`endif
                if (disturb) begin
                    rand_buffer();
                    i_address = MAW'($urandom);
                    i_count   = MAW'($urandom);
                    i_write   = 1'($urandom_range(0, 1));
                end
                if (rdy) k++;
            end else begin
                check("done", obs_bus(), exp_bus(1'b0, 1'b0, 1'b1, last_addr, last_data));
                seen_done = 1'b1;
            end
        end
        if (!seen_done) check("timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("idle", obs_bus(), exp_bus(1'b0, 1'b0, 1'b0, last_addr, last_data));
        $display("xfer %s addr=%0d cnt=%0d words=%0d cycles_presented=%0d", name, addr, cnt, n, writes);
    endtask

    initial begin
        logic [MAW-1:0] ra;
        logic [MAW-1:0] rc;
        i_rst_n   = 1'b0;
        i_write   = 1'b0;
        i_address = '0;
        i_count   = '0;
        rand_buffer();
        last_addr = '0;
        last_data = '0;
`ifdef DMA_WRITER_STALL_EN
        mem_if.mem_ready = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("reset", obs_bus(), 64'd0);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("reset_idle", obs_bus(), 64'd0);

        rand_buffer();
        for (int i = 0; i < 4; i++) i_buffer[i] = 16'hA000 + 16'(i);
        run_xfer("basic", 10'd10, 10'd4, 1'b0, 0);

        rand_buffer();
        run_xfer("zero", 10'd77, 10'd0, 1'b0, 0);

        rand_buffer();
        run_xfer("wrap", 10'd1022, 10'd4, 1'b0, 0);

        rand_buffer();
        run_xfer("clamp", 10'd500, 10'd200, 1'b0, 0);

        rand_buffer();
        run_xfer("disturb", 10'd300, 10'd12, 1'b1, 0);

        // Reset during the third of six writes must drop we without a clock edge.
        rand_buffer();
        i_address = 10'd40;
        i_count   = 10'd6;
        i_write   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_write = 1'b0;
            check("pre_rst", obs_bus(), exp_bus(1'b1, 1'b1, 1'b0, 10'd40 + MAW'(k), i_buffer[k]));
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_async", obs_bus(), 64'd0);
        @(negedge clk);
        check("rst_hold", obs_bus(), 64'd0);
        i_rst_n = 1'b1;
        last_addr = '0;
        last_data = '0;
        @(negedge clk);
        check("rst_idle", obs_bus(), 64'd0);
        $display("xfer reset_abort addr=40 cnt=6 aborted after 3 words");

        rand_buffer();
        run_xfer("after_rst", 10'd5, 10'd6, 1'b0, 0);

        rand_buffer();
        run_xfer("stall_dir", 10'd200, 10'd3, 1'b0, 2);

        for (int t = 0; t < 14; t++) begin
            rand_buffer();
            ra = MAW'($urandom);
            case ($urandom_range(0, 3))
                0:       rc = 10'd0;
                1:       rc = MAW'($urandom_range(1, 8));
                2:       rc = MAW'($urandom_range(100, 130));
                default: rc = MAW'($urandom);
            endcase
            run_xfer("random", ra, rc, 1'($urandom_range(0, 1)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
